// File: rtl/delivery_lane_pkg.sv
// Shared constants and helpers for the delivery game lane pattern sources.
// Holds the lane width, the 16-entry pattern ROM, the default LFSR seed
// and the LFSR next-state function.
package delivery_lane_pkg;

  localparam int LANE_W = 4;

  typedef logic [LANE_W-1:0] lane_t;

  // Seed used when none is given, and the value that replaces an illegal zero.
  localparam lane_t DEFAULT_SEED  = 4'h1;
  localparam lane_t LFSR_FALLBACK = 4'h1;

  // Pattern table, entry 0 in the low nibble. No entry is all-clear or
  // all-set, so every pattern leaves at least one lane free.
  localparam logic [16*LANE_W-1:0] LANE_ROM = {
    4'hE, 4'h7, 4'h8, 4'h2, 4'h4, 4'h1, 4'hA, 4'h5,
    4'h9, 4'hC, 4'h6, 4'h3, 4'h8, 4'h4, 4'h2, 4'h1
  };

  function automatic lane_t rom_read(input lane_t addr);
    return LANE_ROM[{addr, 2'b00} +: LANE_W];
  endfunction

  // Maximal-length 4-bit LFSR: period 15, never reaches zero from a nonzero state.
  function automatic lane_t lfsr_next(input lane_t q);
    return {q[2:0], q[3] ^ q[0]};
  endfunction

endpackage

// File: rtl/lane_lfsr.sv
// 4-bit LFSR that produces the pattern ROM address.
// Steps on advance; reloads to SEED on reset.
// Optional macro LANE_SOURCE_SEED_LOAD_EN adds a runtime seed load port pair.
module lane_lfsr
  import delivery_lane_pkg::*;
#(
  parameter logic [3:0] SEED = DEFAULT_SEED
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              advance,
`ifdef LANE_SOURCE_SEED_LOAD_EN
  input  logic              seed_load,
  input  logic [LANE_W-1:0] seed_value,
`endif
  output logic [LANE_W-1:0] address
);

  // A zero seed would lock the LFSR at zero, so it is swapped for the fallback.
  localparam lane_t SEED_SAFE = (SEED == 4'h0) ? LFSR_FALLBACK : SEED;

  lane_t state_q;
  lane_t state_d;

  // Next-state selection: seed load beats advance, otherwise hold.
  always_comb begin
    state_d = state_q;
`ifdef LANE_SOURCE_SEED_LOAD_EN
    if (seed_load) begin
      state_d = (seed_value == 4'h0) ? LFSR_FALLBACK : seed_value;
    end else if (advance) begin
      state_d = lfsr_next(state_q);
    end
`else
    if (advance) begin
      state_d = lfsr_next(state_q);
    end
`endif
  end

  // State register, cleared to the seed immediately on reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= SEED_SAFE;
    end else begin
      state_q <= state_d;
    end
  end

  assign address = state_q;

endmodule

// File: rtl/delivery_lane_source.sv
// Pseudo-random lane pattern source for one map layer of the delivery game.
// LFSR address -> registered 16x4 pattern ROM -> combinational sel gate.
// Optional macro LANE_SOURCE_SEED_LOAD_EN adds seed_load / seed_value inputs.
module delivery_lane_source
  import delivery_lane_pkg::*;
#(
  parameter logic [3:0] SEED = DEFAULT_SEED
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              advance,
  input  logic              sel,
`ifdef LANE_SOURCE_SEED_LOAD_EN
  input  logic              seed_load,
  input  logic [LANE_W-1:0] seed_value,
`endif
  output logic [LANE_W-1:0] address,
  output logic [LANE_W-1:0] pattern_raw,
  output logic [LANE_W-1:0] pattern_out,
  output logic              pattern_valid
);

  lane_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clock      (clock),
    .reset      (reset),
    .advance    (advance),
`ifdef LANE_SOURCE_SEED_LOAD_EN
    .seed_load  (seed_load),
    .seed_value (seed_value),
`endif
    .address    (address)
  );

  // Synchronous ROM read every edge from the pre-edge address, regardless of advance.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pattern_raw <= '0;
    end else begin
      pattern_raw <= rom_read(address);
    end
  end

  // Output gate: sel passes the registered pattern straight through, no extra register.
  always_comb begin
    pattern_out   = sel ? pattern_raw : '0;
    pattern_valid = sel && (pattern_out != '0);
  end

endmodule

// File: tb/tb_delivery_lane_source.sv
// Self-checking bench for delivery_lane_source.
// Expected outputs are pushed to a scoreboard queue when each edge's stimulus
// is driven and popped/compared after the edge.
module tb_delivery_lane_source;

  logic       clock;
  logic       reset;
  logic       advance;
  logic       sel;
  logic [3:0] address;
  logic [3:0] pattern_raw;
  logic [3:0] pattern_out;
  logic       pattern_valid;
`ifdef LANE_SOURCE_SEED_LOAD_EN
  logic       seed_load;
  logic [3:0] seed_value;
`endif

  typedef struct {
    logic [3:0] addr;
    logic [3:0] raw;
    logic [3:0] out;
    logic       valid;
  } expect_t;

  expect_t sbQueue[$];

  int checkCount = 0;
  int failCount  = 0;

  logic [3:0] benchRom [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'h9,
                                4'h5, 4'hA, 4'h1, 4'h4, 4'h2, 4'h8, 4'h7, 4'hE};
  logic [3:0] seqTable [15] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5,
                                4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8};

  logic [3:0] mAddr;
  logic [3:0] mRaw;

  delivery_lane_source dut (
    .clock         (clock),
    .reset         (reset),
    .advance       (advance),
    .sel           (sel),
`ifdef LANE_SOURCE_SEED_LOAD_EN
    .seed_load     (seed_load),
    .seed_value    (seed_value),
`endif
    .address       (address),
    .pattern_raw   (pattern_raw),
    .pattern_out   (pattern_out),
    .pattern_valid (pattern_valid)
  );

  // Free-running clock, period 10.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [3:0] seqNext(input logic [3:0] a);
    for (int i = 0; i < 15; i++) begin
      if (seqTable[i] == a) return seqTable[(i + 1) % 15];
    end
    return 4'h0;
  endfunction

  task automatic pushExpect(input logic [3:0] nextAddr, input logic s);
    expect_t e;
    e.addr  = nextAddr;
    e.raw   = benchRom[mAddr];
    e.out   = s ? e.raw : 4'h0;
    e.valid = (e.out != 4'h0);
    mAddr   = e.addr;
    mRaw    = e.raw;
    sbQueue.push_back(e);
  endtask

  task automatic compareAfterEdge(input string tag);
    expect_t e;
    @(posedge clock);
    #1;
    if (sbQueue.size() == 0) begin
      checkOutput({tag, "_underflow"}, 0, 1);
    end else begin
      e = sbQueue.pop_front();
      checkOutput({tag, "_addr"},  address,       e.addr);
      checkOutput({tag, "_raw"},   pattern_raw,   e.raw);
      checkOutput({tag, "_out"},   pattern_out,   e.out);
      checkOutput({tag, "_valid"}, pattern_valid, e.valid);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic adv, input logic s);
    advance = adv;
    sel     = s;
    pushExpect(adv ? seqNext(mAddr) : mAddr, s);
    compareAfterEdge(tag);
  endtask

  task automatic doReset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    mAddr = 4'h1;
    mRaw  = 4'h0;
    sbQueue.delete();
  endtask

`ifdef LANE_SOURCE_SEED_LOAD_EN
  task automatic loadSeed(input string tag, input logic [3:0] v);
    seed_load  = 1'b1;
    seed_value = v;
    advance    = 1'b1;
    sel        = 1'b1;
    pushExpect((v == 4'h0) ? 4'h1 : v, 1'b1);
    compareAfterEdge(tag);
    seed_load  = 1'b0;
  endtask
`endif

  initial begin
    reset   = 1'b1;
    advance = 1'b0;
    sel     = 1'b1;
    mAddr   = 4'h1;
    mRaw    = 4'h0;
`ifdef LANE_SOURCE_SEED_LOAD_EN
    seed_load  = 1'b0;
    seed_value = 4'h0;
`endif

    // Reset state.
    #3;
    checkOutput("rst_addr",  address,       4'h1);
    checkOutput("rst_raw",   pattern_raw,   4'h0);
    checkOutput("rst_out",   pattern_out,   4'h0);
    checkOutput("rst_valid", pattern_valid, 1'b0);

    // First three advancing edges: address 3,7,F with patterns 2,8,9.
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus("run3", 1'b1, 1'b1);

    // Advance to 7, then hold for five edges.
    doReset();
    applyStimulus("to7", 1'b1, 1'b1);
    applyStimulus("to7", 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus("hold", 1'b0, 1'b1);
    checkOutput("hold_raw9", pattern_raw, 4'h9);

    // Walk until pattern_raw is 8, then drop sel between edges.
    for (int i = 0; i < 4; i++) applyStimulus("toA", 1'b1, 1'b1);
    checkOutput("pre_sel_out",   pattern_out,   4'h8);
    checkOutput("pre_sel_valid", pattern_valid, 1'b1);
    #2;
    sel = 1'b0;
    #1;
    checkOutput("sel0_out",   pattern_out,   4'h0);
    checkOutput("sel0_valid", pattern_valid, 1'b0);
    checkOutput("sel0_raw",   pattern_raw,   4'h8);
    sel = 1'b1;

    // A few edges with sel low, then walk to address E.
    applyStimulus("sel_low", 1'b1, 1'b0);
    applyStimulus("sel_low", 1'b1, 1'b0);
    for (int i = 0; i < 15 && mAddr != 4'hE; i++) applyStimulus("toE", 1'b1, 1'b1);
    checkOutput("reach_E", address, 4'hE);

    // Asynchronous reset between edges.
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_addr", address,     4'h1);
    checkOutput("async_raw",  pattern_raw, 4'h0);
    reset = 1'b0;
    mAddr = 4'h1;
    mRaw  = 4'h0;
    sbQueue.delete();

    // Full period: 15 advancing edges return to address 1.
    for (int i = 0; i < 15; i++) applyStimulus("period", 1'b1, 1'b1);
    checkOutput("period_wrap", address, 4'h1);

`ifdef LANE_SOURCE_SEED_LOAD_EN
    // Seed load: zero coerced to 1, then B, then ROM[B] on the next edge.
    applyStimulus("pre_seed", 1'b1, 1'b1);
    loadSeed("seed0", 4'h0);
    checkOutput("seed0_addr", address, 4'h1);
    loadSeed("seedB", 4'hB);
    checkOutput("seedB_addr", address, 4'hB);
    applyStimulus("after_seed", 1'b0, 1'b1);
    checkOutput("romB", pattern_raw, 4'h4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
